// File: rtl/if_prefetch_if.sv
// Fetch-side bus bundle: instruction ROM port, decode handshake and datapath redirect.
// The master modport is the prefetch unit; slave is the ROM/decode/datapath side.
interface if_prefetch_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
);
    logic                  rom_req;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [31:0]           rom_rdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] instr_pc;

    modport master (
        output rom_req, rom_addr, instr_valid, instr, instr_pc,
        input  rom_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  rom_req, rom_addr, instr_valid, instr, instr_pc,
        output rom_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generation, synchronous ROM request and a small
// credit-controlled FIFO feeding decode, flushed on datapath redirects.
//
// state   | meaning
// S_RESET | first cycle out of reset, nothing issued yet
// S_RUN   | issuing one fetch per cycle while FIFO credit remains
// S_FULL  | out of credit, waiting for decode to drain the FIFO
module if_prefetch #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           rst,
    if_prefetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 2;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_FULL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic [DATA_WIDTH-1:0] redirect_aligned;
    logic                  inflight;
    logic                  inflight_nxt;
    logic                  rom_req_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [31:0]           mem_instr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic                  credit;
    logic                  credit_nxt;

    // rom_req is registered, so a request already on the bus in a redirect cycle is
    // treated as cancelled: its return is never pushed.
    assign issue            = rom_req_q && !bus.redirect_valid;
    assign push             = inflight && !bus.redirect_valid;
    assign head_valid       = (count != '0);
    assign pop              = head_valid && bus.instr_ready && !bus.redirect_valid;
    assign credit           = (count + CNT_W'(inflight)) < CNT_W'(DEPTH);
    assign redirect_aligned = bus.redirect_pc & ~DATA_WIDTH'(3);

    always_comb begin
        count_nxt    = count;
        inflight_nxt = 1'b0;
        state_nxt    = state;
        if (bus.redirect_valid) begin
            count_nxt = '0;
            state_nxt = S_RUN;
        end else begin
            count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
            inflight_nxt = issue;
            case (state)
                S_RESET:       state_nxt = S_RUN;
                S_RUN, S_FULL: state_nxt = credit ? S_RUN : S_FULL;
                default:       state_nxt = S_RESET;
            endcase
        end
    end

    assign credit_nxt = (count_nxt + CNT_W'(inflight_nxt)) < CNT_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            rom_req_q   <= 1'b0;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state     <= state_nxt;
            rom_req_q <= (state_nxt == S_RUN) && credit_nxt;
            count     <= count_nxt;
            inflight  <= inflight_nxt;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_aligned;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc    <= fetch_pc + DATA_WIDTH'(4);
                    inflight_pc <= fetch_pc;
                end
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= bus.rom_rdata;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end

    assign bus.rom_req     = rom_req_q;
    assign bus.rom_addr    = fetch_pc[ADDR_WIDTH+1:2];
    assign bus.instr_valid = head_valid && !bus.redirect_valid;
    assign bus.instr       = mem_instr[rd_ptr];
    assign bus.instr_pc    = mem_pc[rd_ptr];
endmodule
